// File: rtl/tt_mask_idx_pkg.sv
// Shared types and constants for the vector mask/index credit interface.
// Provides:
//   MASK_WORD_BITS / MASK_ITEM_BITS : mask word and pushed item widths
//   rx_state_e                      : receiver FSM state encoding
//   mask_item_t                     : pushed item layout (reserved bit + mask word)
package tt_mask_idx_pkg;
  localparam int MASK_WORD_BITS = 64;
  localparam int MASK_ITEM_BITS = 65;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic                      rsvd;
    logic [MASK_WORD_BITS-1:0] word;
  } mask_item_t;
endpackage

// File: rtl/tt_mask_idx_fifo.sv
// DEPTH x 64 flop FIFO holding buffered mask words.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   push, din       : write a word (caller guarantees a free slot or a same-cycle pop)
//   pop             : retire the head word (caller guarantees non-empty)
//   flush           : discard all contents, wins over push/pop
//   head            : word at the read pointer
//   full, empty     : occupancy flags
//   count           : current occupancy
module tt_mask_idx_fifo
  import tt_mask_idx_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                push,
  input  logic [MASK_WORD_BITS-1:0]           din,
  input  logic                                pop,
  input  logic                                flush,
  output logic [MASK_WORD_BITS-1:0]           head,
  output logic                                full,
  output logic                                empty,
  output logic [$clog2(DEPTH+1)-1:0]          count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [MASK_WORD_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]             wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/tt_mask_idx_rx.sv
// LSU-side receiver for the vector mask/index credit interface.
// Buffers pushed 64-bit mask words, serialises them into a per-element mask
// stream bounded by the vl captured at op start, and returns one credit per
// freed FIFO entry.
// Ports:
//   i_clk, i_reset_n                      : clock, async active-low reset
//   i_mask_idx_item/_valid/_last_idx      : word push from the sender
//   o_mask_idx_credit                     : one-cycle pulse per freed entry
//   i_start, i_vl                         : op start and element count
//   i_flush                               : abort op, drop buffered words
//   o_elem_valid/_mask/_idx/_last, i_elem_ready : element stream
//   o_busy                                : op in progress
//   o_overflow                            : sticky, push seen while full
module tt_mask_idx_rx
  import tt_mask_idx_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int VLEN  = 256
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [MASK_ITEM_BITS-1:0]   i_mask_idx_item,
  input  logic                        i_mask_idx_valid,
  input  logic                        i_mask_idx_last_idx,
  output logic                        o_mask_idx_credit,
  input  logic                        i_start,
  input  logic [$clog2(VLEN+1)-1:0]   i_vl,
  input  logic                        i_flush,
  output logic                        o_elem_valid,
  output logic                        o_elem_mask,
  output logic [$clog2(VLEN)-1:0]     o_elem_idx,
  output logic                        o_elem_last,
  input  logic                        i_elem_ready,
  output logic                        o_busy,
  output logic                        o_overflow
);
  localparam int VLW = $clog2(VLEN + 1);
  localparam int IW  = $clog2(VLEN);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int BW  = $clog2(MASK_WORD_BITS);

  mask_item_t                item;
  rx_state_e                 state_q, state_d;
  logic [VLW-1:0]            vl_q;
  logic [IW-1:0]             elem_idx_q;
  logic [BW-1:0]             bit_ptr_q;
  logic [CW-1:0]             pend_q, fifo_count;
  logic [CW:0]               avail;
  logic                      credit_q, overflow_q, issue;
  logic [MASK_WORD_BITS-1:0] head;
  logic                      full, empty;
  logic                      hs, pop, push_ok, start_op;
  logic                      unused_bits;

  assign item        = i_mask_idx_item;
  assign unused_bits = item.rsvd ^ i_mask_idx_last_idx;

  assign o_busy       = (state_q == ACTIVE);
  assign o_elem_valid = o_busy && !empty;
  assign o_elem_mask  = o_elem_valid && head[bit_ptr_q];
  assign o_elem_idx   = elem_idx_q;
  assign o_elem_last  = o_busy && (VLW'(elem_idx_q) == vl_q - VLW'(1));
  assign o_mask_idx_credit = credit_q;
  assign o_overflow   = overflow_q;

  // Flush suppresses every other action in its cycle.
  assign hs       = o_elem_valid && i_elem_ready && !i_flush;
  assign pop      = hs && ((bit_ptr_q == '1) || o_elem_last);
  assign start_op = !o_busy && !i_flush && i_start && (i_vl != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = i_mask_idx_valid && !i_flush && (!full || pop);

  tt_mask_idx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .push  (push_ok),
    .din   (item.word),
    .pop   (pop),
    .flush (i_flush),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    if (i_flush) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (start_op) state_d = ACTIVE;
        ACTIVE:  if (hs && o_elem_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Credits owed this cycle: backlog plus whatever is freed now. One leaves
  // per cycle so a pop with no backlog is credited on the very next cycle.
  always_comb begin
    avail = (CW+1)'(pend_q) + (i_flush ? (CW+1)'(fifo_count) : (CW+1)'(pop));
    issue = (avail != '0);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      vl_q       <= '0;
      elem_idx_q <= '0;
      bit_ptr_q  <= '0;
      pend_q     <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= CW'(avail - (CW+1)'(issue));
      credit_q <= issue;
      if (i_mask_idx_valid && !i_flush && full && !pop) overflow_q <= 1'b1;
      if (i_flush) begin
        elem_idx_q <= '0;
        bit_ptr_q  <= '0;
      end else if (start_op) begin
        vl_q       <= i_vl;
        elem_idx_q <= '0;
        bit_ptr_q  <= '0;
      end else if (hs) begin
        elem_idx_q <= elem_idx_q + 1'b1;
        bit_ptr_q  <= bit_ptr_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tt_mask_idx_rx.sv
// Self-checking bench for tt_mask_idx_rx: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_tt_mask_idx_rx;
  localparam int DEPTH = 2;
  localparam int VLEN  = 256;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [64:0] i_mask_idx_item = '0;
  logic        i_mask_idx_valid = 1'b0;
  logic        i_mask_idx_last_idx = 1'b0;
  logic        o_mask_idx_credit;
  logic        i_start = 1'b0;
  logic [8:0]  i_vl = '0;
  logic        i_flush = 1'b0;
  logic        o_elem_valid, o_elem_mask, o_elem_last;
  logic [7:0]  o_elem_idx;
  logic        i_elem_ready = 1'b0;
  logic        o_busy, o_overflow;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [63:0] mq[$];
  bit          m_busy, m_credit, m_ovf;
  int          m_vl, m_idx, m_pend;

  tt_mask_idx_rx #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_mask_idx_item(i_mask_idx_item), .i_mask_idx_valid(i_mask_idx_valid),
    .i_mask_idx_last_idx(i_mask_idx_last_idx), .o_mask_idx_credit(o_mask_idx_credit),
    .i_start(i_start), .i_vl(i_vl), .i_flush(i_flush),
    .o_elem_valid(o_elem_valid), .o_elem_mask(o_elem_mask), .o_elem_idx(o_elem_idx),
    .o_elem_last(o_elem_last), .i_elem_ready(i_elem_ready),
    .o_busy(o_busy), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic clear_inputs();
    i_mask_idx_item = '0; i_mask_idx_valid = 0; i_mask_idx_last_idx = 0;
    i_start = 0; i_vl = '0; i_flush = 0; i_elem_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset_n = 0;
    repeat (2) @(negedge i_clk);
    i_reset_n = 1;
    mq.delete(); m_busy = 0; m_credit = 0; m_ovf = 0; m_vl = 0; m_idx = 0; m_pend = 0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Spec-level model: element k of an op reads bit k%64 of the head word;
  // freed entries become owed credits, paid out one per cycle.
  task automatic model_step();
    bit v, lst, hs, pop, pushq;
    int freed;
    v   = m_busy && (mq.size() > 0);
    lst = m_busy && (m_idx == m_vl - 1);
    hs  = v && i_elem_ready && !i_flush;
    pop = hs && ((m_idx % 64) == 63 || lst);
    freed = i_flush ? mq.size() : int'(pop);
    m_pend += freed;
    m_credit = (m_pend > 0);
    if (m_credit) m_pend--;
    pushq = 0;
    if (i_flush) begin
      mq.delete(); m_busy = 0; m_idx = 0;
    end else begin
      if (i_mask_idx_valid) begin
        if (mq.size() < DEPTH || pop) pushq = 1;
        else m_ovf = 1;
      end
      if (pop) void'(mq.pop_front());
      if (pushq) mq.push_back(i_mask_idx_item[63:0]);
      if (hs) begin
        m_idx++;
        if (lst) m_busy = 0;
      end else if (!m_busy && i_start && i_vl != 0) begin
        m_busy = 1; m_vl = int'(i_vl); m_idx = 0;
      end
    end
  endtask

  task automatic test_reset();
    i_reset_n = 0;
    #1;
    checks++;
    if ({o_mask_idx_credit, o_elem_valid, o_elem_mask, o_elem_idx, o_elem_last, o_busy, o_overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {o_mask_idx_credit, o_elem_valid, o_elem_mask,
               o_elem_idx, o_elem_last, o_busy, o_overflow});
    end
    do_reset();
  endtask

  task automatic test_vl5();
    logic [63:0] w;
    do_reset();
    w = 64'h15;
    i_start = 1; i_vl = 9'd5; tick();
    i_start = 0; i_mask_idx_valid = 1; i_mask_idx_item = {1'b0, w}; tick();
    i_mask_idx_valid = 0; i_elem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_elem_valid !== 1 || o_elem_idx !== 8'(i) || o_elem_mask !== w[i] ||
          o_elem_last !== (i == 4) || o_mask_idx_credit !== 0) begin
        failures++;
        $display("FAIL vl5_elem%0d got v=%b idx=%0d m=%b l=%b c=%b exp v=1 idx=%0d m=%b l=%b c=0",
                 i, o_elem_valid, o_elem_idx, o_elem_mask, o_elem_last, o_mask_idx_credit,
                 i, w[i], (i == 4));
      end
      tick();
    end
    checks++;
    if (o_mask_idx_credit !== 1 || o_busy !== 0 || o_elem_valid !== 0) begin
      failures++;
      $display("FAIL vl5_end got c=%b busy=%b v=%b exp c=1 busy=0 v=0",
               o_mask_idx_credit, o_busy, o_elem_valid);
    end
    tick();
    checks++;
    if (o_mask_idx_credit !== 0) begin
      failures++;
      $display("FAIL vl5_single_credit got=%b exp=0", o_mask_idx_credit);
    end
    i_elem_ready = 0;
  endtask

  task automatic test_vl130();
    logic [63:0] w[3];
    logic [63:0] cw;
    int sc, nsent, ndone, errs, first, lastc;
    int cpos[$];
    do_reset();
    for (int k = 0; k < 3; k++) w[k] = rnd64();
    sc = DEPTH; nsent = 0; ndone = 0; errs = 0; first = -1; lastc = -1;
    i_start = 1; i_vl = 9'd130; i_elem_ready = 1; tick();
    i_start = 0;
    for (int cyc = 0; cyc < 170; cyc++) begin
      if (o_mask_idx_credit) begin cpos.push_back(ndone); sc++; end
      if (o_elem_valid && i_elem_ready) begin
        cw = w[ndone / 64];
        if (o_elem_idx !== 8'(ndone) || o_elem_mask !== cw[ndone % 64] ||
            o_elem_last !== (ndone == 129)) errs++;
        if (first < 0) first = cyc;
        lastc = cyc;
        ndone++;
      end
      i_mask_idx_valid = 0;
      if (sc > 0 && nsent < 3) begin
        i_mask_idx_valid = 1; i_mask_idx_item = {1'b0, w[nsent]}; nsent++; sc--;
      end
      tick();
    end
    i_mask_idx_valid = 0; i_elem_ready = 0;
    checks++;
    if (errs != 0 || ndone != 130) begin
      failures++;
      $display("FAIL vl130_elems got errs=%0d count=%0d exp errs=0 count=130", errs, ndone);
    end
    checks++;
    if (lastc - first != 129) begin
      failures++;
      $display("FAIL vl130_back_to_back got span=%0d exp=129", lastc - first);
    end
    checks++;
    if (cpos.size() != 3 || cpos[0] != 64 || cpos[1] != 128 || cpos[2] != 130) begin
      failures++;
      $display("FAIL vl130_credits got n=%0d pos=%p exp n=3 pos=64,128,130", cpos.size(), cpos);
    end
  endtask

  task automatic test_stall_overflow_flush();
    int errs;
    do_reset();
    errs = 0;
    i_start = 1; i_vl = 9'd200; tick();
    i_start = 0; i_mask_idx_valid = 1; i_mask_idx_item = {1'b0, rnd64()}; tick();
    i_mask_idx_item = {1'b0, rnd64()}; tick();
    i_mask_idx_valid = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_elem_valid !== 1 || o_elem_idx !== 0 || o_mask_idx_credit !== 0 || o_overflow !== 0) errs++;
      tick();
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL stall_hold got bad_cycles=%0d exp=0", errs);
    end
    i_mask_idx_valid = 1; i_mask_idx_item = {1'b0, rnd64()}; tick();
    i_mask_idx_valid = 0;
    checks++;
    if (o_overflow !== 1) begin
      failures++;
      $display("FAIL overflow_set got=%b exp=1", o_overflow);
    end
    // push during the flush cycle must be dropped
    i_flush = 1; i_mask_idx_valid = 1; tick();
    i_flush = 0; i_mask_idx_valid = 0;
    checks++;
    if (o_busy !== 0 || o_elem_valid !== 0 || o_mask_idx_credit !== 1) begin
      failures++;
      $display("FAIL flush_c1 got busy=%b v=%b c=%b exp busy=0 v=0 c=1", o_busy, o_elem_valid, o_mask_idx_credit);
    end
    tick();
    checks++;
    if (o_mask_idx_credit !== 1) begin
      failures++;
      $display("FAIL flush_c2 got=%b exp=1", o_mask_idx_credit);
    end
    tick();
    checks++;
    if (o_mask_idx_credit !== 0 || o_overflow !== 1) begin
      failures++;
      $display("FAIL flush_c3 got c=%b ovf=%b exp c=0 ovf=1", o_mask_idx_credit, o_overflow);
    end
    i_start = 1; i_vl = 9'd1; tick();
    i_start = 0; tick();
    checks++;
    if (o_busy !== 1 || o_elem_valid !== 0) begin
      failures++;
      $display("FAIL flush_drop_push got busy=%b v=%b exp busy=1 v=0", o_busy, o_elem_valid);
    end
    i_flush = 1; tick(); i_flush = 0;
  endtask

  task automatic test_vl0();
    int errs;
    logic [63:0] w;
    do_reset();
    errs = 0;
    w = rnd64();
    i_mask_idx_valid = 1; i_mask_idx_item = {1'b0, w}; tick();
    i_mask_idx_valid = 0; i_start = 1; i_vl = 9'd0; i_elem_ready = 1; tick();
    i_start = 0;
    for (int i = 0; i < 3; i++) begin
      if (o_busy !== 0 || o_elem_valid !== 0) errs++;
      tick();
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL vl0_idle got bad_cycles=%0d exp=0", errs);
    end
    i_elem_ready = 0; i_start = 1; i_vl = 9'd1; tick();
    i_start = 0;
    checks++;
    if (o_elem_valid !== 1 || o_elem_mask !== w[0] || o_elem_last !== 1) begin
      failures++;
      $display("FAIL pre_start_retained got v=%b m=%b l=%b exp v=1 m=%b l=1",
               o_elem_valid, o_elem_mask, o_elem_last, w[0]);
    end
    i_flush = 1; tick(); i_flush = 0;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    i_start = 1; i_vl = 9'd1; tick();
    i_start = 0; i_mask_idx_valid = 1; i_mask_idx_item = {1'b0, 64'h1}; tick();
    i_mask_idx_item = {1'b0, 64'h2}; tick();
    i_mask_idx_item = {1'b0, 64'h3}; i_elem_ready = 1; tick();
    i_mask_idx_valid = 0; i_elem_ready = 0;
    checks++;
    if (o_overflow !== 0 || o_busy !== 0 || o_mask_idx_credit !== 1) begin
      failures++;
      $display("FAIL full_push_pop got ovf=%b busy=%b c=%b exp ovf=0 busy=0 c=1",
               o_overflow, o_busy, o_mask_idx_credit);
    end
    i_start = 1; tick();
    checks++;
    if (o_elem_valid !== 1 || o_elem_mask !== 0) begin
      failures++;
      $display("FAIL fifo_order_w1 got v=%b m=%b exp v=1 m=0", o_elem_valid, o_elem_mask);
    end
    i_start = 0; i_elem_ready = 1; tick();
    i_elem_ready = 0; i_start = 1; tick();
    i_start = 0;
    checks++;
    if (o_elem_valid !== 1 || o_elem_mask !== 1) begin
      failures++;
      $display("FAIL fifo_order_w2 got v=%b m=%b exp v=1 m=1", o_elem_valid, o_elem_mask);
    end
    i_flush = 1; tick(); i_flush = 0;
  endtask

  task automatic test_async_reset();
    int sc, errs;
    bit hit;
    do_reset();
    sc = DEPTH; hit = 0; errs = 0;
    i_start = 1; i_vl = 9'd200; i_elem_ready = 1; tick();
    i_start = 0;
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      if (o_elem_valid && o_elem_idx == 8'd70) hit = 1;
      else begin
        if (o_mask_idx_credit) sc++;
        i_mask_idx_valid = 0;
        if (sc > 0) begin i_mask_idx_valid = 1; i_mask_idx_item = {1'b0, rnd64()}; sc--; end
        tick();
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL async_reset_reach_idx70 got=timeout exp=idx70");
    end
    #2 i_reset_n = 0;
    #1;
    checks++;
    if ({o_mask_idx_credit, o_elem_valid, o_elem_mask, o_elem_idx, o_elem_last, o_busy, o_overflow} !== '0) begin
      failures++;
      $display("FAIL async_reset_outputs got=%b exp=0", {o_mask_idx_credit, o_elem_valid, o_elem_mask,
               o_elem_idx, o_elem_last, o_busy, o_overflow});
    end
    clear_inputs();
    @(negedge i_clk);
    i_reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_mask_idx_credit !== 0 || o_busy !== 0 || o_elem_valid !== 0) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL async_reset_no_credit got bad_cycles=%0d exp=0", errs);
    end
  endtask

  task automatic test_random();
    int sc;
    bit e_valid, e_mask, e_last;
    logic [63:0] hw;
    do_reset();
    sc = DEPTH;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge i_clk);
      model_step();
      @(negedge i_clk);
      e_valid = m_busy && (mq.size() > 0);
      hw = e_valid ? mq[0] : 64'h0;
      e_mask = e_valid && hw[m_idx % 64];
      e_last = m_busy && (m_idx == m_vl - 1);
      checks++;
      if (o_elem_valid !== e_valid || o_elem_mask !== e_mask || o_elem_last !== e_last) begin
        failures++;
        $display("FAIL rand_elem cyc=%0d got v=%b m=%b l=%b exp v=%b m=%b l=%b",
                 cyc, o_elem_valid, o_elem_mask, o_elem_last, e_valid, e_mask, e_last);
      end
      checks++;
      if (o_elem_idx !== 8'(m_idx % VLEN) || o_busy !== m_busy) begin
        failures++;
        $display("FAIL rand_idx_busy cyc=%0d got idx=%0d busy=%b exp idx=%0d busy=%b",
                 cyc, o_elem_idx, o_busy, m_idx % VLEN, m_busy);
      end
      checks++;
      if (o_mask_idx_credit !== m_credit || o_overflow !== m_ovf) begin
        failures++;
        $display("FAIL rand_credit_ovf cyc=%0d got c=%b ovf=%b exp c=%b ovf=%b",
                 cyc, o_mask_idx_credit, o_overflow, m_credit, m_ovf);
      end
      if (o_mask_idx_credit) sc++;
      i_flush = ($urandom % 300 == 0);
      i_mask_idx_valid = 0;
      if (!i_flush && sc > 0 && ($urandom % 2 == 0)) begin
        i_mask_idx_valid = 1; sc--;
      end
      i_mask_idx_item = {1'($urandom), $urandom, $urandom};
      i_mask_idx_last_idx = 1'($urandom);
      i_elem_ready = ($urandom % 4 != 0);
      i_start = (!m_busy && $urandom % 6 == 0) || ($urandom % 25 == 0);
      if ($urandom % 8 == 0) i_vl = 9'd0;
      else if ($urandom % 16 == 0) i_vl = 9'd256;
      else i_vl = 9'($urandom_range(1, 160));
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_vl5();
    test_vl130();
    test_stall_overflow_flush();
    test_vl0();
    test_full_push_pop();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
